// File: rtl/pll_phase_ctrl.sv
// EHXPLLL dynamic phase-shift sequencer with a filtered lock indicator.
// Optional build macro PLL_AUTORELOCK_EN adds an automatic pll_rst pulse after a sustained loss of lock.
module pll_phase_ctrl #(
  parameter int LOCK_CYCLES  = 1024,
  parameter int PULSE_CYCLES = 4,
  parameter int STEP_W       = 8
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic              pll_lock,
  output logic              locked,
  input  logic              ps_req,
  input  logic [1:0]        ps_sel,
  input  logic              ps_dir,
  input  logic [STEP_W-1:0] ps_steps,
  output logic              ps_busy,
  output logic              ps_ack,
  output logic              ps_err,
  output logic [1:0]        pll_phasesel,
  output logic              pll_phasedir,
  output logic              pll_phasestep,
  output logic              pll_phaseloadreg,
  output logic              pll_rst
);

  localparam int LCW = $clog2(LOCK_CYCLES + 1);
  localparam int PCW = $clog2(PULSE_CYCLES + 1);

  typedef enum logic [2:0] {IDLE, SETUP, STEP_LO, STEP_HI, LOAD, DONE} state_t;

  logic              lock_meta_reg;
  logic              lock_sync_reg;
  logic [LCW-1:0]    lock_cnt_reg;
  state_t            state_reg;
  logic [PCW-1:0]    pulse_cnt_reg;
  logic [STEP_W-1:0] steps_left_reg;
  logic              pulse_done;

  assign pulse_done = (pulse_cnt_reg == PCW'(PULSE_CYCLES - 1));

  // Two-flop synchroniser plus saturating consecutive-high filter.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      lock_meta_reg <= 1'b0;
      lock_sync_reg <= 1'b0;
      lock_cnt_reg  <= '0;
      locked        <= 1'b0;
    end else begin
      lock_meta_reg <= pll_lock;
      lock_sync_reg <= lock_meta_reg;
      if (!lock_sync_reg) begin
        lock_cnt_reg <= '0;
        locked       <= 1'b0;
      end else begin
        if (lock_cnt_reg != LCW'(LOCK_CYCLES))
          lock_cnt_reg <= lock_cnt_reg + 1'b1;
        if (lock_cnt_reg >= LCW'(LOCK_CYCLES - 1))
          locked <= 1'b1;
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= IDLE;
      pulse_cnt_reg    <= '0;
      steps_left_reg   <= '0;
      ps_busy          <= 1'b0;
      ps_ack           <= 1'b0;
      ps_err           <= 1'b0;
      pll_phasesel     <= 2'd0;
      pll_phasedir     <= 1'b1;
      pll_phasestep    <= 1'b1;
      pll_phaseloadreg <= 1'b1;
    end else begin
      ps_ack <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (ps_req) begin
            ps_busy <= 1'b1;
            if (!locked) begin
              state_reg <= DONE;
              ps_ack    <= 1'b1;
              ps_err    <= 1'b1;
            end else if (ps_steps == '0) begin
              state_reg <= DONE;
              ps_ack    <= 1'b1;
              ps_err    <= 1'b0;
            end else begin
              state_reg      <= SETUP;
              pulse_cnt_reg  <= '0;
              steps_left_reg <= ps_steps;
              pll_phasesel   <= ps_sel;
              pll_phasedir   <= ps_dir;
            end
          end
        end
        DONE: begin
          state_reg <= IDLE;
          ps_busy   <= 1'b0;
          ps_err    <= 1'b0;
        end
        default: begin
          if (!locked) begin
            // Lock lost mid-sequence: drop every pin back to idle at once.
            state_reg        <= DONE;
            ps_ack           <= 1'b1;
            ps_err           <= 1'b1;
            pll_phasesel     <= 2'd0;
            pll_phasedir     <= 1'b1;
            pll_phasestep    <= 1'b1;
            pll_phaseloadreg <= 1'b1;
          end else if (!pulse_done) begin
            pulse_cnt_reg <= pulse_cnt_reg + 1'b1;
          end else begin
            pulse_cnt_reg <= '0;
            case (state_reg)
              SETUP: begin
                state_reg     <= STEP_LO;
                pll_phasestep <= 1'b0;
              end
              STEP_LO: begin
                state_reg     <= STEP_HI;
                pll_phasestep <= 1'b1;
              end
              STEP_HI: begin
                if (steps_left_reg == STEP_W'(1)) begin
                  state_reg        <= LOAD;
                  pll_phaseloadreg <= 1'b0;
                end else begin
                  steps_left_reg <= steps_left_reg - 1'b1;
                  state_reg      <= STEP_LO;
                  pll_phasestep  <= 1'b0;
                end
              end
              default: begin
                state_reg        <= DONE;
                ps_ack           <= 1'b1;
                ps_err           <= 1'b0;
                pll_phaseloadreg <= 1'b1;
                pll_phasesel     <= 2'd0;
                pll_phasedir     <= 1'b1;
              end
            endcase
          end
        end
      endcase
    end
  end

`ifdef PLL_AUTORELOCK_EN
  localparam int RCW = $clog2(LOCK_CYCLES + PULSE_CYCLES + 1);

  typedef enum logic [1:0] {RL_WATCH, RL_PULSE, RL_HOLD} relock_t;

  relock_t        relock_state_reg;
  logic [RCW-1:0] relock_cnt_reg;
  logic           relock_armed_reg;

  // Armed once lock has been seen; after a pulse, hold off one lock window before watching again.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      relock_state_reg <= RL_WATCH;
      relock_cnt_reg   <= '0;
      relock_armed_reg <= 1'b0;
      pll_rst          <= 1'b0;
    end else begin
      if (locked)
        relock_armed_reg <= 1'b1;
      case (relock_state_reg)
        RL_WATCH: begin
          if (relock_armed_reg && !lock_sync_reg) begin
            if (relock_cnt_reg == RCW'(LOCK_CYCLES - 1)) begin
              relock_cnt_reg   <= '0;
              pll_rst          <= 1'b1;
              relock_state_reg <= RL_PULSE;
            end else begin
              relock_cnt_reg <= relock_cnt_reg + 1'b1;
            end
          end else begin
            relock_cnt_reg <= '0;
          end
        end
        RL_PULSE: begin
          if (relock_cnt_reg == RCW'(PULSE_CYCLES - 1)) begin
            relock_cnt_reg   <= '0;
            pll_rst          <= 1'b0;
            relock_state_reg <= RL_HOLD;
          end else begin
            relock_cnt_reg <= relock_cnt_reg + 1'b1;
          end
        end
        default: begin
          if (relock_cnt_reg == RCW'(LOCK_CYCLES - 1)) begin
            relock_cnt_reg   <= '0;
            relock_state_reg <= RL_WATCH;
          end else begin
            relock_cnt_reg <= relock_cnt_reg + 1'b1;
          end
        end
      endcase
    end
  end
`else
  assign pll_rst = 1'b0;
`endif

endmodule
